// File: rtl/frame_packer.sv
// Wraps a raw 32-bit word stream into frames: {SYNC, seq} header, 1..MAX_LEN payload
// words, then a {len, csum} trailer. A single output register sits on the m_* side.
module frame_packer #(
   parameter int          DATA_WIDTH = 32,
   parameter int          MAX_LEN    = 256,
   parameter int          TIMEOUT    = 2000,
   parameter logic [15:0] SYNC       = 16'hA55A
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  flush,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [15:0]           frame_cnt,
   output logic                  busy
);

   localparam int             IW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT - 1);
   localparam logic [15:0]    LEN_LAST  = 16'(MAX_LEN);

   typedef enum logic [1:0] {IDLE, PAY, TRL} state_t;

   state_t                  state_reg, state_next;
   logic                    m_valid_reg, m_valid_next;
   logic [DATA_WIDTH-1:0]   m_data_reg, m_data_next;
   logic [15:0]             len_reg, len_next;
   logic [DATA_WIDTH-1:0]   xor_reg, xor_next;
   logic [IW-1:0]           idle_cnt_reg, idle_cnt_next;
   logic [15:0]             seq_reg, seq_next;
   logic [15:0]             frame_cnt_reg, frame_cnt_next;
   logic                    flush_latch_reg, flush_latch_next;

   logic                    slot_free;
   logic                    accept;
   logic                    flush_pend;
   logic [15:0]             len_inc;

   assign slot_free  = !m_valid_reg || m_ready;
   assign s_ready    = (state_reg == PAY) && slot_free;
   assign accept     = s_ready && s_valid;
   assign flush_pend = flush || flush_latch_reg;
   assign len_inc    = len_reg + 16'd1;

   assign m_valid   = m_valid_reg;
   assign m_data    = m_data_reg;
   assign frame_cnt = frame_cnt_reg;
   assign busy      = (state_reg != IDLE) || m_valid_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         m_valid_reg     <= 1'b0;
         m_data_reg      <= '0;
         len_reg         <= '0;
         xor_reg         <= '0;
         idle_cnt_reg    <= '0;
         seq_reg         <= '0;
         frame_cnt_reg   <= '0;
         flush_latch_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         m_valid_reg     <= m_valid_next;
         m_data_reg      <= m_data_next;
         len_reg         <= len_next;
         xor_reg         <= xor_next;
         idle_cnt_reg    <= idle_cnt_next;
         seq_reg         <= seq_next;
         frame_cnt_reg   <= frame_cnt_next;
         flush_latch_reg <= flush_latch_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      // A word leaving the output register empties it unless something new is loaded.
      m_valid_next     = slot_free ? 1'b0 : m_valid_reg;
      m_data_next      = m_data_reg;
      len_next         = len_reg;
      xor_next         = xor_reg;
      idle_cnt_next    = idle_cnt_reg;
      seq_next         = seq_reg;
      frame_cnt_next   = frame_cnt_reg;
      flush_latch_next = flush_latch_reg;

      case (state_reg)
         IDLE: begin
            if (enable && s_valid && slot_free) begin
               m_valid_next  = 1'b1;
               m_data_next   = {SYNC, seq_reg};
               len_next      = '0;
               xor_next      = '0;
               idle_cnt_next = '0;
               state_next    = PAY;
            end
         end
         PAY: begin
            if (accept) begin
               m_valid_next  = 1'b1;
               m_data_next   = s_data;
               len_next      = len_inc;
               xor_next      = xor_reg ^ s_data;
               idle_cnt_next = '0;
               if ((len_inc == LEN_LAST) || flush_pend) begin
                  state_next       = TRL;
                  flush_latch_next = 1'b0;
               end
            end else if (len_reg != 16'd0) begin
               if (flush_pend) begin
                  state_next       = TRL;
                  flush_latch_next = 1'b0;
               end else if (idle_cnt_reg == IDLE_LAST) begin
                  state_next = TRL;
               end else begin
                  idle_cnt_next = idle_cnt_reg + 1'b1;
               end
            end else if (flush) begin
               // Empty frame: hold the flush until the first payload word lands.
               flush_latch_next = 1'b1;
            end
         end
         TRL: begin
            if (slot_free) begin
               m_valid_next   = 1'b1;
               m_data_next    = {len_reg, xor_reg[31:16] ^ xor_reg[15:0]};
               seq_next       = seq_reg + 16'd1;
               frame_cnt_next = frame_cnt_reg + 16'd1;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
